// File: rtl/dsp_axi4lite_wb_pkg.sv
// Shared types and constants for the AXI4-Lite to multi-channel Wishbone crossbar.
package dsp_axi4lite_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RESP = 2'd2
    } xbar_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // A single channel still needs one select bit so the field is never zero-width.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dsp_wb_timeout_ctr.sv
// Counts Wishbone strobe cycles and flags the cycle in which the wait budget runs out.
module dsp_wb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Fires in the TIMEOUT-th strobe cycle, so strobe lasts exactly TIMEOUT cycles.
    assign o_expired = i_en && (r_count == LIMIT);

endmodule

// File: rtl/dsp_axi4lite_wb_xbar.sv
// AXI4-Lite slave fanning out to NCH Wishbone DSP cores, one transaction in flight at a time.
module dsp_axi4lite_wb_xbar
    import dsp_axi4lite_wb_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int NCH              = 4,
    parameter int CH_SEL_LSB       = 16,
    parameter int TIMEOUT          = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [C_AXI_ADDR_WIDTH-1:0]       i_axi_awaddr,
    input  logic [2:0]                        i_axi_awprot,
    input  logic                              i_axi_awvalid,
    output logic                              o_axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]       i_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]     i_axi_wstrb,
    input  logic                              i_axi_wvalid,
    output logic                              o_axi_wready,
    output logic [1:0]                        o_axi_bresp,
    output logic                              o_axi_bvalid,
    input  logic                              i_axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]       i_axi_araddr,
    input  logic [2:0]                        i_axi_arprot,
    input  logic                              i_axi_arvalid,
    output logic                              o_axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]       o_axi_rdata,
    output logic [1:0]                        o_axi_rresp,
    output logic                              o_axi_rvalid,
    input  logic                              i_axi_rready,
    output logic                              o_wb_rst,
    output logic [NCH-1:0]                    o_wb_cyc,
    output logic [NCH-1:0]                    o_wb_stb,
    output logic                              o_wb_we,
    output logic [CH_SEL_LSB-3:0]             o_wb_adr,
    output logic [C_AXI_DATA_WIDTH-1:0]       o_wb_dat,
    output logic [C_AXI_DATA_WIDTH/8-1:0]     o_wb_sel,
    input  logic [NCH*C_AXI_DATA_WIDTH-1:0]   i_wb_dat,
    input  logic [NCH-1:0]                    i_wb_ack,
    input  logic [NCH-1:0]                    i_wb_err
);

    localparam int CH_W = ch_width(NCH);
    localparam int DW   = C_AXI_DATA_WIDTH;

    xbar_state_t r_state, w_state_nxt;

    logic                  r_last_was_write;
    logic                  r_we;
    logic [CH_SEL_LSB-3:0] r_adr;
    logic [DW-1:0]         r_dat;
    logic [DW/8-1:0]       r_sel;
    logic [NCH-1:0]        r_cyc;
    logic [1:0]            r_resp;
    logic [DW-1:0]         r_rdata;
    logic [1:0]            r_rst_sync;

    logic                        w_idle, w_wr_req, w_grant_wr, w_grant_rd, w_grant;
    logic [C_AXI_ADDR_WIDTH-1:0] w_addr;
    logic [CH_W-1:0]             w_ch;
    logic                        w_dec_ok;
    logic [NCH-1:0]              w_onehot;
    logic                        w_ack, w_err, w_expired, w_in_wb, w_wb_done;
    logic [DW-1:0]               w_rd_mux;
    logic                        w_unused_ok;

    // Handshakes are strict AXI valid/ready: a beat transfers on a rising edge where both are high;
    // ready is only offered in IDLE, and AW/W are always accepted together in the same cycle.
    assign w_idle     = (r_state == IDLE) && rst_ni;
    assign w_wr_req   = i_axi_awvalid && i_axi_wvalid;
    assign w_grant_wr = w_idle && w_wr_req && (!i_axi_arvalid || !r_last_was_write);
    assign w_grant_rd = w_idle && i_axi_arvalid && !w_grant_wr;
    assign w_grant    = w_grant_wr || w_grant_rd;

    assign o_axi_awready = w_grant_wr;
    assign o_axi_wready  = w_grant_wr;
    assign o_axi_arready = w_grant_rd;

    assign w_addr   = w_grant_wr ? i_axi_awaddr : i_axi_araddr;
    assign w_ch     = w_addr[CH_SEL_LSB +: CH_W];
    assign w_dec_ok = (int'(w_ch) < NCH) && ((w_addr >> (CH_SEL_LSB + CH_W)) == '0);

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_onehot[k] = (int'(w_ch) == k);
        end
    end

    // Only the channel holding the cycle may complete it; stray ack/err elsewhere are masked.
    assign w_in_wb   = (r_state == WB);
    assign w_ack     = w_in_wb && |(i_wb_ack & r_cyc);
    assign w_err     = w_in_wb && |(i_wb_err & r_cyc);
    assign w_wb_done = w_ack || w_err || w_expired;

    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_cyc[k]) begin
                w_rd_mux = w_rd_mux | i_wb_dat[k*DW +: DW];
            end
        end
    end

    dsp_wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_clr     (w_grant),
        .i_en      (w_in_wb),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = w_dec_ok ? WB : RESP;
                end
            end
            WB: begin
                if (w_wb_done) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (r_we ? i_axi_bready : i_axi_rready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_was_write <= 1'b0;
            r_we             <= 1'b0;
            r_adr            <= '0;
            r_dat            <= '0;
            r_sel            <= '0;
            r_cyc            <= '0;
            r_resp           <= RESP_OKAY;
            r_rdata          <= '0;
        end else if (w_grant) begin
            r_last_was_write <= w_grant_wr;
            r_we             <= w_grant_wr;
            r_adr            <= w_addr[CH_SEL_LSB-1:2];
            if (w_grant_wr) begin
                r_dat <= i_axi_wdata;
                r_sel <= i_axi_wstrb;
            end else begin
                r_sel <= '1;
            end
            r_cyc   <= w_dec_ok ? w_onehot : '0;
            r_resp  <= w_dec_ok ? RESP_OKAY : RESP_DECERR;
            r_rdata <= '0;
        end else if (w_wb_done) begin
            // Ack takes priority over a coinciding timeout.
            r_cyc   <= '0;
            r_resp  <= w_ack ? RESP_OKAY : RESP_SLVERR;
            r_rdata <= (w_ack && !r_we) ? w_rd_mux : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign o_wb_rst     = r_rst_sync[1];
    assign o_wb_cyc     = r_cyc;
    assign o_wb_stb     = r_cyc;
    assign o_wb_we      = r_we;
    assign o_wb_adr     = r_adr;
    assign o_wb_dat     = r_dat;
    assign o_wb_sel     = r_sel;
    assign o_axi_bvalid = (r_state == RESP) && r_we;
    assign o_axi_rvalid = (r_state == RESP) && !r_we;
    assign o_axi_bresp  = r_resp;
    assign o_axi_rresp  = r_resp;
    assign o_axi_rdata  = r_rdata;

    assign w_unused_ok = ^{i_axi_awprot, i_axi_arprot, w_addr[1:0]};

endmodule

// File: tb/tb_dsp_axi4lite_wb_xbar.sv
// Directed bench for dsp_axi4lite_wb_xbar: scoreboard queues checked by a negedge monitor.
module tb_dsp_axi4lite_wb_xbar;

    localparam int NCH = 4;
    localparam int TMO = 8;

    // ---------------- clock / reset ----------------
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [31:0]      i_axi_awaddr, i_axi_wdata, i_axi_araddr;
    logic [2:0]       i_axi_awprot, i_axi_arprot;
    logic [3:0]       i_axi_wstrb;
    logic             i_axi_awvalid, i_axi_wvalid, i_axi_arvalid, i_axi_bready, i_axi_rready;
    logic             o_axi_awready, o_axi_wready, o_axi_arready, o_axi_bvalid, o_axi_rvalid;
    logic [1:0]       o_axi_bresp, o_axi_rresp;
    logic [31:0]      o_axi_rdata;
    logic             o_wb_rst, o_wb_we;
    logic [NCH-1:0]   o_wb_cyc, o_wb_stb, i_wb_ack, i_wb_err;
    logic [13:0]      o_wb_adr;
    logic [31:0]      o_wb_dat;
    logic [3:0]       o_wb_sel;
    logic [NCH*32-1:0] i_wb_dat;

    dsp_axi4lite_wb_xbar #(
        .C_AXI_DATA_WIDTH (32),
        .C_AXI_ADDR_WIDTH (32),
        .NCH              (NCH),
        .CH_SEL_LSB       (16),
        .TIMEOUT          (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .i_axi_awaddr  (i_axi_awaddr),
        .i_axi_awprot  (i_axi_awprot),
        .i_axi_awvalid (i_axi_awvalid),
        .o_axi_awready (o_axi_awready),
        .i_axi_wdata   (i_axi_wdata),
        .i_axi_wstrb   (i_axi_wstrb),
        .i_axi_wvalid  (i_axi_wvalid),
        .o_axi_wready  (o_axi_wready),
        .o_axi_bresp   (o_axi_bresp),
        .o_axi_bvalid  (o_axi_bvalid),
        .i_axi_bready  (i_axi_bready),
        .i_axi_araddr  (i_axi_araddr),
        .i_axi_arprot  (i_axi_arprot),
        .i_axi_arvalid (i_axi_arvalid),
        .o_axi_arready (o_axi_arready),
        .o_axi_rdata   (o_axi_rdata),
        .o_axi_rresp   (o_axi_rresp),
        .o_axi_rvalid  (o_axi_rvalid),
        .i_axi_rready  (i_axi_rready),
        .o_wb_rst      (o_wb_rst),
        .o_wb_cyc      (o_wb_cyc),
        .o_wb_stb      (o_wb_stb),
        .o_wb_we       (o_wb_we),
        .o_wb_adr      (o_wb_adr),
        .o_wb_dat      (o_wb_dat),
        .o_wb_sel      (o_wb_sel),
        .i_wb_dat      (i_wb_dat),
        .i_wb_ack      (i_wb_ack),
        .i_wb_err      (i_wb_err)
    );

    // Wishbone slaves: mode 0 = zero-wait ack, 1 = zero-wait err, 2 = never answers.
    logic [1:0] slv_mode [NCH];
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            i_wb_ack[k] = o_wb_stb[k] && (slv_mode[k] == 2'd0);
            i_wb_err[k] = o_wb_stb[k] && (slv_mode[k] == 2'd1);
        end
    end
    assign i_wb_dat = {32'h3333_0003, 32'h2222_0002, 32'hCAFE_F00D, 32'h1111_0000};

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];   // {is_write, resp, rdata}
    logic [54:0] wb_q[$];    // {cyc, we, adr, dat, sel}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [NCH-1:0] mon_prev_cyc = '0;
    logic [34:0]    mon_e;
    logic [54:0]    mon_w;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if ((o_axi_bvalid && i_axi_bready) || (o_axi_rvalid && i_axi_rready)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_dir", {63'd0, o_axi_bvalid}, {63'd0, mon_e[34]});
                    if (mon_e[34]) begin
                        check("bresp", {62'd0, o_axi_bresp}, {62'd0, mon_e[33:32]});
                    end else begin
                        check("rresp", {62'd0, o_axi_rresp}, {62'd0, mon_e[33:32]});
                        check("rdata", {32'd0, o_axi_rdata}, {32'd0, mon_e[31:0]});
                    end
                end
            end
            if (o_wb_cyc != '0 && mon_prev_cyc == '0) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_wb_cycle", {60'd0, o_wb_cyc}, 64'd0);
                end else begin
                    mon_w = wb_q.pop_front();
                    check("wb_cyc", {60'd0, o_wb_cyc}, {60'd0, mon_w[54:51]});
                    check("wb_stb", {60'd0, o_wb_stb}, {60'd0, mon_w[54:51]});
                    check("wb_we", {63'd0, o_wb_we}, {63'd0, mon_w[50]});
                    check("wb_adr", {50'd0, o_wb_adr}, {50'd0, mon_w[49:36]});
                    if (mon_w[50]) begin
                        check("wb_dat", {32'd0, o_wb_dat}, {32'd0, mon_w[35:4]});
                        check("wb_sel", {60'd0, o_wb_sel}, {60'd0, mon_w[3:0]});
                    end
                end
            end
        end
        mon_prev_cyc = o_wb_cyc;
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        int n;
        if (wr) begin
            i_axi_awaddr  = addr;
            i_axi_wdata   = data;
            i_axi_wstrb   = strb;
            i_axi_awvalid = 1'b1;
            i_axi_wvalid  = 1'b1;
        end else begin
            i_axi_araddr  = addr;
            i_axi_arvalid = 1'b1;
        end
        n = 0;
        forever begin
            @(negedge clk_i);
            if (wr ? (o_axi_awready && o_axi_wready) : o_axi_arready) break;
            n++;
            if (n > 50) begin
                check("grant_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        i_axi_awvalid = 1'b0;
        i_axi_wvalid  = 1'b0;
        i_axi_arvalid = 1'b0;
    endtask

    task automatic wait_resp(output int lat, output int stbn);
        lat  = 0;
        stbn = 0;
        repeat (100) begin
            @(negedge clk_i);
            lat++;
            if (o_wb_stb != '0) stbn++;
            if (o_axi_bvalid || o_axi_rvalid) break;
        end
    endtask

    task automatic finish_resp();
        repeat (100) begin
            if ((o_axi_bvalid && i_axi_bready) || (o_axi_rvalid && i_axi_rready)) break;
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic txn(input string name, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input logic [1:0] resp,
                       input logic [31:0] rdata, input int ch, input int exp_lat, input int exp_stb);
        int lat, stbn;
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        exp_q.push_back({wr, resp, rdata});
        if (ch >= 0) wb_q.push_back({oh, wr, addr[15:2], data, strb});
        issue(wr, addr, data, strb);
        wait_resp(lat, stbn);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_stb_cycles"}, 64'(stbn), 64'(exp_stb));
        finish_resp();
    endtask

    task automatic arb_round(input bit exp_wr, input logic [31:0] wdat);
        int lat, stbn;
        if (exp_wr) begin
            exp_q.push_back({1'b1, 2'b00, 32'h0});
            wb_q.push_back({4'b0001, 1'b1, 14'h0002, wdat, 4'hF});
        end else begin
            exp_q.push_back({1'b0, 2'b00, 32'hCAFE_F00D});
            wb_q.push_back({4'b0010, 1'b0, 14'h0003, 32'h0, 4'h0});
        end
        i_axi_awaddr  = 32'h0000_0008;
        i_axi_wdata   = wdat;
        i_axi_wstrb   = 4'hF;
        i_axi_araddr  = 32'h0001_000C;
        i_axi_awvalid = 1'b1;
        i_axi_wvalid  = 1'b1;
        i_axi_arvalid = 1'b1;
        @(negedge clk_i);
        check("arb_awready", {63'd0, o_axi_awready}, {63'd0, exp_wr});
        check("arb_arready", {63'd0, o_axi_arready}, {63'd0, !exp_wr});
        @(posedge clk_i);
        #1;
        i_axi_awvalid = 1'b0;
        i_axi_wvalid  = 1'b0;
        i_axi_arvalid = 1'b0;
        wait_resp(lat, stbn);
        check("arb_latency", 64'(lat), 64'd2);
        finish_resp();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, stbn;
        for (int k = 0; k < NCH; k++) slv_mode[k] = 2'd0;
        i_axi_awaddr = '0; i_axi_wdata = '0; i_axi_wstrb = '0; i_axi_araddr = '0;
        i_axi_awprot = 3'd0; i_axi_arprot = 3'd0;
        i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1; i_axi_arvalid = 1'b1;
        i_axi_bready = 1'b1; i_axi_rready = 1'b1;

        // Reset values, with requests pending to confirm nothing is accepted in reset.
        #12;
        check("rst_awready", {63'd0, o_axi_awready}, 64'd0);
        check("rst_arready", {63'd0, o_axi_arready}, 64'd0);
        check("rst_valids", {62'd0, o_axi_bvalid, o_axi_rvalid}, 64'd0);
        check("rst_cyc_stb", {56'd0, o_wb_cyc, o_wb_stb}, 64'd0);
        check("rst_we_adr", {49'd0, o_wb_we, o_wb_adr}, 64'd0);
        check("rst_dat_sel", {28'd0, o_wb_dat, o_wb_sel}, 64'd0);
        check("rst_resps", {60'd0, o_axi_bresp, o_axi_rresp}, 64'd0);
        check("rst_rdata", {32'd0, o_axi_rdata}, 64'd0);
        check("rst_wb_rst", {63'd0, o_wb_rst}, 64'd1);
        i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0; i_axi_arvalid = 1'b0;
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("wb_rst_released", {63'd0, o_wb_rst}, 64'd0);

        txn("wr_ch2", 1'b1, 32'h0002_0010, 32'h1234_5678, 4'hF, 2'b00, 32'h0, 2, 2, 1);
        txn("rd_ch1", 1'b0, 32'h0001_0004, 32'h0, 4'h0, 2'b00, 32'hCAFE_F00D, 1, 2, 1);
        txn("rd_decerr", 1'b0, 32'h0100_0000, 32'h0, 4'h0, 2'b11, 32'h0, -1, 1, 0);
        txn("wr_decerr", 1'b1, 32'h0004_0000, 32'h0000_00AA, 4'hF, 2'b11, 32'h0, -1, 1, 0);

        slv_mode[0] = 2'd1;
        txn("wr_slverr", 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'h3, 2'b10, 32'h0, 0, 2, 1);
        slv_mode[0] = 2'd0;

        slv_mode[3] = 2'd2;
        txn("rd_timeout", 1'b0, 32'h0003_0008, 32'h0, 4'h0, 2'b10, 32'h0, 3, TMO + 1, TMO);
        slv_mode[3] = 2'd0;

        // Last grant above was a read, so ties now alternate write, read, write.
        arb_round(1'b1, 32'hA5A5_0001);
        arb_round(1'b0, 32'hA5A5_0002);
        arb_round(1'b1, 32'hA5A5_0003);

        // Back-pressure on B: response must hold and no new request may be granted.
        i_axi_bready = 1'b0;
        exp_q.push_back({1'b1, 2'b00, 32'h0});
        wb_q.push_back({4'b0001, 1'b1, 14'h0000, 32'h0000_0055, 4'hF});
        issue(1'b1, 32'h0000_0000, 32'h0000_0055, 4'hF);
        wait_resp(lat, stbn);
        check("bp_latency", 64'(lat), 64'd2);
        i_axi_araddr  = 32'h0001_0000;
        i_axi_arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_bvalid_held", {63'd0, o_axi_bvalid}, 64'd1);
            check("bp_no_grant", {59'd0, o_axi_arready, o_wb_cyc}, 64'd0);
        end
        @(posedge clk_i);
        #1;
        i_axi_arvalid = 1'b0;
        i_axi_bready  = 1'b1;
        @(negedge clk_i);
        finish_resp();

        // Reset in the middle of a Wishbone cycle aborts it with no response.
        slv_mode[2] = 2'd2;
        wb_q.push_back({4'b0100, 1'b0, 14'h0000, 32'h0, 4'h0});
        issue(1'b0, 32'h0002_0000, 32'h0, 4'h0);
        @(negedge clk_i);
        check("abort_cyc_before", {60'd0, o_wb_cyc}, 64'h4);
        #2 rst_ni = 1'b0;
        #1;
        check("abort_cyc_stb", {56'd0, o_wb_cyc, o_wb_stb}, 64'd0);
        check("abort_rvalid", {63'd0, o_axi_rvalid}, 64'd0);
        check("abort_wb_rst", {63'd0, o_wb_rst}, 64'd1);
        slv_mode[2] = 2'd0;
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("wb_rst_edge1", {63'd0, o_wb_rst}, 64'd1);
        @(posedge clk_i);
        #1;
        check("wb_rst_edge2", {63'd0, o_wb_rst}, 64'd0);
        txn("rd_after_rst", 1'b0, 32'h0002_0004, 32'h0, 4'h0, 2'b00, 32'h2222_0002, 2, 2, 1);

        repeat (3) @(posedge clk_i);
        #1;
        check("resp_queue_empty", 64'(exp_q.size()), 64'd0);
        check("wb_queue_empty", 64'(wb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
